// File: rtl/sr_cmd_sched.sv
// Two-requester command scheduler that pulses S/R drives of an SR latch bank and tracks the expected contents.
// Optional readback checking of the latch bank is enabled by defining SR_SCHED_READBACK_EN.
module sr_cmd_sched #(
    parameter int N_LATCH   = 4,
    parameter int PULSE_CYC = 2,
    localparam int IW       = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [1:0]         op,
    input  logic [IW-1:0]      idx0,
    input  logic [IW-1:0]      idx1,
    output logic [1:0]         ack,
    output logic [N_LATCH-1:0] S,
    output logic [N_LATCH-1:0] R,
    output logic               busy,
    output logic [N_LATCH-1:0] shadow,
    input  logic [N_LATCH-1:0] latch_q,
    output logic               err,
    output logic [1:0]         dbg_state
);

    // Handshake: requester i holds req[i] (with op[i]/idx) high until it sees the
    // one-cycle ack[i]; only the values present at the grant edge are used.

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    localparam int CNT_W = 4;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               prio;
    logic               cur_gnt;
    logic               cur_op;
    logic [IW-1:0]      cur_idx;

    logic               gnt_id;
    logic               sel_op;
    logic [IW-1:0]      sel_idx;
    logic [N_LATCH-1:0] dec;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // prio names the requester that wins when both are asking; it is the one not granted last.
    always_comb begin
        gnt_id = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = prio;
            default: gnt_id = 1'b0;
        endcase
        sel_idx      = gnt_id ? idx1 : idx0;
        sel_op       = op[gnt_id];
        dec          = '0;
        dec[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            prio    <= 1'b0;
            cur_gnt <= 1'b0;
            cur_op  <= 1'b0;
            cur_idx <= '0;
            S       <= '0;
            R       <= '0;
            ack     <= '0;
            shadow  <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state   <= ST_PULSE;
                        prio    <= ~gnt_id;
                        cur_gnt <= gnt_id;
                        cur_op  <= sel_op;
                        cur_idx <= sel_idx;
                        cnt     <= CNT_W'(PULSE_CYC - 1);
                        S       <= sel_op ? dec : '0;
                        R       <= sel_op ? '0 : dec;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state           <= ST_GUARD;
                        S               <= '0;
                        R               <= '0;
                        ack[cur_gnt]    <= 1'b1;
                        shadow[cur_idx] <= cur_op;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GUARD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    S     <= '0;
                    R     <= '0;
                end
            endcase
        end
    end

`ifdef SR_SCHED_READBACK_EN
    // The latch has settled by GUARD, so its Q must now equal the commanded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == ST_GUARD && latch_q[cur_idx] != cur_op) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_latch_q;
    assign unused_latch_q = ^latch_q;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_sr_cmd_sched.sv
// Directed bench for sr_cmd_sched: timing, arbitration, reset abort and readback behaviour.
module tb_sr_cmd_sched;

    localparam int N  = 4;
    localparam int PC = 2;
`ifdef SR_SCHED_READBACK_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif
    localparam logic [1:0] ST_GUARD = 2'd2;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   op;
    logic [1:0]   idx0;
    logic [1:0]   idx1;
    logic [1:0]   ack;
    logic [N-1:0] S;
    logic [N-1:0] R;
    logic         busy;
    logic [N-1:0] shadow;
    logic [N-1:0] latch_q;
    logic         err;
    logic [1:0]   dbg_state;

    logic [N-1:0] latch_m = '0;
    logic [N-1:0] stuck0  = '0;

    int total   = 0;
    int passes  = 0;
    int fails   = 0;
    int overlap = 0;
    int ack_bad = 0;

    sr_cmd_sched #(.N_LATCH(N), .PULSE_CYC(PC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx0(idx0), .idx1(idx1),
        .ack(ack), .S(S), .R(R), .busy(busy), .shadow(shadow),
        .latch_q(latch_q), .err(err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural latch bank; stuck0 forces chosen Q bits low.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (S[k]) latch_m[k] <= 1'b1;
            else if (R[k]) latch_m[k] <= 1'b0;
        end
    end
    assign latch_q = latch_m & ~stuck0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (|(S & R)) overlap++;
            if (ack == 2'b11) ack_bad++;
            if (ack != 2'b00 && dbg_state != ST_GUARD) ack_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        op    = 2'b00;
        idx0  = 2'd0;
        idx1  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        op    = 2'b00;
        idx0  = 2'd0;
        idx1  = 2'd0;
        step();
        chk("rst_S", 32'(S), 32'h0);
        chk("rst_R", 32'(R), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_shadow", 32'(shadow), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        step();
        rst_n = 1'b1;

        // Single set of latch 2 by requester 0
        req = 2'b01; op = 2'b01; idx0 = 2'd2;
        step();
        chk("set_S_c1", 32'(S), 32'h4);
        chk("set_R_c1", 32'(R), 32'h0);
        chk("set_busy", 32'(busy), 32'h1);
        step();
        chk("set_S_c2", 32'(S), 32'h4);
        chk("set_ack_c2", 32'(ack), 32'h0);
        step();
        chk("set_S_guard", 32'(S), 32'h0);
        chk("set_ack", 32'(ack), 32'h1);
        chk("set_shadow", 32'(shadow), 32'h4);
        chk("set_state", 32'(dbg_state), 32'(ST_GUARD));
        req = 2'b00;
        step();
        chk("set_ack_off", 32'(ack), 32'h0);
        chk("set_idle", 32'(busy), 32'h0);

        // Changes during PULSE are ignored
        req = 2'b01; op = 2'b01; idx0 = 2'd1;
        step();
        chk("ign_S_c1", 32'(S), 32'h2);
        req = 2'b11; op = 2'b10; idx0 = 2'd3; idx1 = 2'd0;
        step();
        chk("ign_S_c2", 32'(S), 32'h2);
        chk("ign_R_c2", 32'(R), 32'h0);
        step();
        chk("ign_ack", 32'(ack), 32'h1);
        chk("ign_shadow", 32'(shadow), 32'h6);
        step();
        chk("ign_idle", 32'(busy), 32'h0);
        step();
        chk("rr_S_req1", 32'(S), 32'h1);
        req = 2'b01;
        step();
        step();
        chk("rr_ack1", 32'(ack), 32'h2);
        chk("rr_shadow", 32'(shadow), 32'h7);
        step();
        // Reset of an already-reset latch still pulses
        step();
        chk("redund_R", 32'(R), 32'h8);
        chk("redund_S", 32'(S), 32'h0);
        step();
        step();
        chk("redund_ack", 32'(ack), 32'h1);
        chk("redund_shadow", 32'(shadow), 32'h7);
        req = 2'b00;
        step();

        // Contention: opposite commands to latch 1
        do_reset();
        chk("cont_shadow0", 32'(shadow), 32'h0);
        req = 2'b11; op = 2'b01; idx0 = 2'd1; idx1 = 2'd1;
        step();
        chk("cont_S_first", 32'(S), 32'h2);
        chk("cont_R_first", 32'(R), 32'h0);
        step();
        step();
        chk("cont_ack0", 32'(ack), 32'h1);
        chk("cont_shadow_a", 32'(shadow), 32'h2);
        req = 2'b10;
        step();
        step();
        chk("cont_R_second", 32'(R), 32'h2);
        chk("cont_S_second", 32'(S), 32'h0);
        step();
        step();
        chk("cont_ack1", 32'(ack), 32'h2);
        chk("cont_shadow_b", 32'(shadow), 32'h0);
        req = 2'b00;
        step();
        chk("cont_idle", 32'(busy), 32'h0);

        // Fairness with both requesters held
        do_reset();
        req = 2'b11; op = 2'b10; idx0 = 2'd0; idx1 = 2'd3;
        for (int i = 0; i < 6; i++) begin
            step();
            step();
            step();
            chk($sformatf("fair_ack_%0d", i), 32'(ack), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end
        req = 2'b00;
        chk("fair_shadow", 32'(shadow), 32'h8);
        step();

        // Reset asserted in the second PULSE cycle
        req = 2'b01; op = 2'b01; idx0 = 2'd0;
        step();
        chk("abort_S_c1", 32'(S), 32'h1);
        step();
        chk("abort_S_c2", 32'(S), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_S", 32'(S), 32'h0);
        chk("abort_R", 32'(R), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_shadow", 32'(shadow), 32'h0);
        step();
        step();
        chk("abort_hold", 32'(busy), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", 32'(busy), 32'h0);
        step();
        chk("post_rst_grant", 32'(busy), 32'h1);
        chk("post_rst_S", 32'(S), 32'h1);
        step();
        step();
        chk("post_rst_ack", 32'(ack), 32'h1);
        chk("post_rst_shadow", 32'(shadow), 32'h1);
        req = 2'b00;
        step();

        // Readback: latch 3 stuck low during a set
        chk("rb_err_before", 32'(err), 32'h0);
        stuck0 = 4'b1000;
        req = 2'b01; op = 2'b01; idx0 = 2'd3;
        step();
        step();
        step();
        chk("rb_ack", 32'(ack), 32'h1);
        req = 2'b00;
        step();
        chk("rb_err_set", 32'(err), 32'(RB));
        stuck0 = 4'b0000;
        req = 2'b01; op = 2'b01; idx0 = 2'd2;
        step();
        step();
        step();
        req = 2'b00;
        step();
        chk("rb_err_sticky", 32'(err), 32'(RB));
        chk("rb_shadow", 32'(shadow), 32'hd);

        chk("no_SR_overlap", 32'(overlap), 32'h0);
        chk("ack_onehot_guard", 32'(ack_bad), 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
